// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary encoder front end.
package rotary_pkg;

    typedef enum logic [2:0] {
        REST,
        CW1,
        CW2,
        CW3,
        CCW1,
        CCW2,
        CCW3,
        RESYNC
    } rot_state_t;

    localparam logic [1:0] DETENT_AB        = 2'b00;
    localparam int         DEBOUNCE_DEFAULT = 5000;

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a stability counter for one raw pin.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int CNT_W           = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // mismatch has persisted long enough: accept the new level
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/rotary_step_ctrl.sv
// Debounces encoder/button pins, decodes full quadrature detents and emits
// registered one-cycle cw/ccw/btn/illegal strobes for the LED rotator.
module rotary_step_ctrl
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic rot_a,
    input  logic rot_b,
    input  logic rot_press,
    output logic cw,
    output logic ccw,
    output logic btn,
    output logic illegal
);

    logic       a_db;
    logic       b_db;
    logic       press_db;
    logic       press_q;
    logic [1:0] ab;
    rot_state_t state;
    rot_state_t state_nxt;
    logic       cw_ev;
    logic       ccw_ev;
    logic       ill_ev;

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_a (
        .clk(clk), .rst(rst), .din(rot_a), .dout(a_db)
    );
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_b (
        .clk(clk), .rst(rst), .din(rot_b), .dout(b_db)
    );
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_press (
        .clk(clk), .rst(rst), .din(rot_press), .dout(press_db)
    );

    assign ab = {a_db, b_db};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= REST;
            press_q <= 1'b0;
            cw      <= 1'b0;
            ccw     <= 1'b0;
            btn     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            press_q <= press_db;
            // a held button swallows detents; a fresh press also lands here
            cw      <= cw_ev & ~press_db;
            ccw     <= ccw_ev & ~press_db;
            btn     <= press_db & ~press_q;
            illegal <= ill_ev;
        end
    end

    always_comb begin
        state_nxt = state;
        cw_ev     = 1'b0;
        ccw_ev    = 1'b0;
        ill_ev    = 1'b0;
        case (state)
            REST: begin
                case (ab)
                    2'b10:   state_nxt = CW1;
                    2'b01:   state_nxt = CCW1;
                    2'b11:   begin state_nxt = RESYNC; ill_ev = 1'b1; end
                    default: state_nxt = REST;
                endcase
            end
            CW1: begin
                case (ab)
                    2'b11:     state_nxt = CW2;
                    DETENT_AB: state_nxt = REST;
                    2'b01:     begin state_nxt = RESYNC; ill_ev = 1'b1; end
                    default:   state_nxt = CW1;
                endcase
            end
            CW2: begin
                case (ab)
                    2'b01:     state_nxt = CW3;
                    2'b10:     state_nxt = CW1;
                    DETENT_AB: begin state_nxt = RESYNC; ill_ev = 1'b1; end
                    default:   state_nxt = CW2;
                endcase
            end
            CW3: begin
                case (ab)
                    DETENT_AB: begin state_nxt = REST; cw_ev = 1'b1; end
                    2'b11:     state_nxt = CW2;
                    2'b10:     begin state_nxt = RESYNC; ill_ev = 1'b1; end
                    default:   state_nxt = CW3;
                endcase
            end
            CCW1: begin
                case (ab)
                    2'b11:     state_nxt = CCW2;
                    DETENT_AB: state_nxt = REST;
                    2'b10:     begin state_nxt = RESYNC; ill_ev = 1'b1; end
                    default:   state_nxt = CCW1;
                endcase
            end
            CCW2: begin
                case (ab)
                    2'b10:     state_nxt = CCW3;
                    2'b01:     state_nxt = CCW1;
                    DETENT_AB: begin state_nxt = RESYNC; ill_ev = 1'b1; end
                    default:   state_nxt = CCW2;
                endcase
            end
            CCW3: begin
                case (ab)
                    DETENT_AB: begin state_nxt = REST; ccw_ev = 1'b1; end
                    2'b11:     state_nxt = CCW2;
                    2'b01:     begin state_nxt = RESYNC; ill_ev = 1'b1; end
                    default:   state_nxt = CCW3;
                endcase
            end
            RESYNC: begin
                if (ab == DETENT_AB) state_nxt = REST;
            end
            default: state_nxt = REST;
        endcase
    end

endmodule
